muldiv_ctrl: RTL and testbench

- Multi-cycle multiply/divide unit and sequencer for the HI/LO register pair of the pipelined MIPS core.
- Sits beside the single-cycle EX-stage ALU. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX and runs division as an iterative restoring sequence.
- Exposes busy so the hazard unit can stall MFHI/MFLO and any new mul/div operation.

---
 rtl/muldiv_ctrl.sv | 168 ++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl.sv
// Multi-cycle HI/LO multiply/divide sequencer: multiply with a fixed commit delay, 32-step restoring divide.
// Optional MADD/MSUB accumulate ops are enabled by defining MULDIV_MADD_EN.
module muldiv_ctrl #(
    parameter int MUL_LAT   = 5,
    parameter int DIV_STEPS = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        cancel,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;
    typedef enum logic [1:0] {ACC_NONE, ACC_ADD, ACC_SUB} acc_t;

    state_t      state;
    acc_t        acc;
    logic [4:0]  cnt;
    logic [63:0] prod;
    logic [31:0] rem;
    logic [31:0] quo;
    logic [31:0] dvs;
    logic        qneg;
    logic        rneg;

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [32:0] trial;
    logic [32:0] diff;
    logic [31:0] step_rem;
    logic [31:0] step_quo;
    logic [63:0] mul_result;

    // Sign-extending to 64 bits keeps the low 64 bits of the product exact for signed operands.
    assign prod_s = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
    assign prod_u = {32'd0, rs_val} * {32'd0, rt_val};
    assign abs_a  = rs_val[31] ? (32'd0 - rs_val) : rs_val;
    assign abs_b  = rt_val[31] ? (32'd0 - rt_val) : rt_val;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        trial    = {rem, quo[31]};
        diff     = trial - {1'b0, dvs};
        step_rem = trial[31:0];
        step_quo = {quo[30:0], 1'b0};
        if (!diff[32]) begin
            step_rem = diff[31:0];
            step_quo = {quo[30:0], 1'b1};
        end
    end

    always_comb begin
        mul_result = prod;
        case (acc)
            ACC_ADD: mul_result = {hi, lo} + prod;
            ACC_SUB: mul_result = {hi, lo} - prod;
            default: mul_result = prod;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= ACC_NONE;
            busy  <= 1'b0;
            cnt   <= 5'd0;
            prod  <= 64'd0;
            rem   <= 32'd0;
            quo   <= 32'd0;
            dvs   <= 32'd0;
            qneg  <= 1'b0;
            rneg  <= 1'b0;
            hi    <= 32'd0;
            lo    <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !cancel) begin
                        case (op)
                            3'd0, 3'd1: begin
                                prod  <= (op == 3'd0) ? prod_s : prod_u;
                                acc   <= ACC_NONE;
                                cnt   <= 5'(MUL_LAT - 1);
                                state <= MUL;
                                busy  <= 1'b1;
                            end
                            3'd2, 3'd3: begin
                                // A zero divisor runs on raw operands so the sequence itself yields hi=rs, lo=all ones.
                                if (op == 3'd3 || rt_val == 32'd0) begin
                                    quo  <= rs_val;
                                    dvs  <= rt_val;
                                    qneg <= 1'b0;
                                    rneg <= 1'b0;
                                end else begin
                                    quo  <= abs_a;
                                    dvs  <= abs_b;
                                    qneg <= rs_val[31] ^ rt_val[31];
                                    rneg <= rs_val[31];
                                end
                                rem   <= 32'd0;
                                cnt   <= 5'(DIV_STEPS - 1);
                                state <= DIV;
                                busy  <= 1'b1;
                            end
                            3'd4: hi <= rs_val;
                            3'd5: lo <= rs_val;
`ifdef MULDIV_MADD_EN
                            3'd6, 3'd7: begin
                                prod  <= prod_s;
                                acc   <= (op == 3'd6) ? ACC_ADD : ACC_SUB;
                                cnt   <= 5'(MUL_LAT - 1);
                                state <= MUL;
                                busy  <= 1'b1;
                            end
`endif
                            default: ;
                        endcase
                    end
                end
                MUL: begin
                    if (cancel) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (cnt == 5'd0) begin
                        {hi, lo} <= mul_result;
                        state    <= IDLE;
                        busy     <= 1'b0;
                    end else begin
                        cnt <= cnt - 5'd1;
                    end
                end
                DIV: begin
                    if (cancel) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        rem <= step_rem;
                        quo <= step_quo;
                        if (cnt == 5'd0) state <= FIX;
                        else             cnt   <= cnt - 5'd1;
                    end
                end
                FIX: begin
                    if (!cancel) begin
                        hi <= rneg ? (32'd0 - rem) : rem;
                        lo <= qneg ? (32'd0 - quo) : quo;
                    end
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: expected hi/lo pushed at issue, popped when busy falls.
module tb_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] rs_val = 32'd0;
    logic [31:0] rt_val = 32'd0;
    logic        cancel = 1'b0;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       name;
        logic [63:0] hilo;
    } exp_t;

    exp_t sb[$];

    muldiv_ctrl #(.MUL_LAT(5), .DIV_STEPS(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .rs_val(rs_val), .rt_val(rt_val), .cancel(cancel),
        .busy(busy), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic push(input string name, input logic [31:0] eh, input logic [31:0] el);
        exp_t e;
        e.name = name;
        e.hilo = {eh, el};
        sb.push_back(e);
    endtask

    // Monitor: every busy 1->0 transition presents a result to compare.
    logic prev_busy = 1'b0;
    always @(negedge clk) begin
        if (prev_busy && !busy) begin
            if (sb.size() == 0) begin
                check("unexpected_commit", {hi, lo}, 64'hxxxxxxxx_xxxxxxxx);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check(e.name, {hi, lo}, e.hilo);
            end
        end
        prev_busy = busy;
    end

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic c);
        @(negedge clk);
        start = 1'b1; op = o; rs_val = a; rt_val = b; cancel = c;
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    int n;

    initial begin
        repeat (2) @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_hilo", {hi, lo}, 64'd0);
        rst_n = 1'b1;

        push("mult", 32'hFFFFFFFF, 32'hFFFFFFFA);
        issue(3'd0, 32'hFFFFFFFE, 32'd3, 1'b0);
        wait_idle(n);
        check("mult_busy_len", 64'(n), 64'd5);

        push("multu", 32'h00000002, 32'hFFFFFFFA);
        issue(3'd1, 32'hFFFFFFFE, 32'd3, 1'b0);
        wait_idle(n);

        push("div_neg7_2", 32'hFFFFFFFF, 32'hFFFFFFFD);
        issue(3'd2, 32'hFFFFFFF9, 32'd2, 1'b0);
        wait_idle(n);
        check("div_busy_len", 64'(n), 64'd33);

        push("divu_by0", 32'd7, 32'hFFFFFFFF);
        issue(3'd3, 32'd7, 32'd0, 1'b0);
        wait_idle(n);

        push("div_by0", 32'hFFFFFFF9, 32'hFFFFFFFF);
        issue(3'd2, 32'hFFFFFFF9, 32'd0, 1'b0);
        wait_idle(n);

        push("div_ovf", 32'd0, 32'h80000000);
        issue(3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        wait_idle(n);

        issue(3'd4, 32'h12345678, 32'd0, 1'b0);
        check("mthi_busy", 64'(busy), 64'd0);
        check("mthi_hilo", {hi, lo}, {32'h12345678, 32'h80000000});
        issue(3'd5, 32'hCAFEF00D, 32'd0, 1'b0);
        check("mtlo_hilo", {hi, lo}, {32'h12345678, 32'hCAFEF00D});

        push("div_with_mtlo", 32'd2, 32'd14);
        issue(3'd2, 32'd100, 32'd7, 1'b0);
        issue(3'd5, 32'hDEADBEEF, 32'd0, 1'b0);
        wait_idle(n);

        push("div_cancel", 32'd2, 32'd14);
        issue(3'd2, 32'd1000, 32'd3, 1'b0);
        repeat (9) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        check("cancel_busy", 64'(busy), 64'd0);
        @(negedge clk);

        issue(3'd0, 32'd5, 32'd5, 1'b1);
        check("start_cancel_busy", 64'(busy), 64'd0);
        @(negedge clk);
        check("start_cancel_hilo", {hi, lo}, {32'd2, 32'd14});

        issue(3'd4, 32'd0, 32'd0, 1'b0);
        issue(3'd5, 32'hFFFFFFFF, 32'd0, 1'b0);
`ifdef MULDIV_MADD_EN
        push("madd", 32'd1, 32'd0);
        issue(3'd6, 32'd1, 32'd1, 1'b0);
        wait_idle(n);
        check("madd_busy_len", 64'(n), 64'd5);
        push("msub", 32'd0, 32'hFFFFFFFA);
        issue(3'd7, 32'd2, 32'd3, 1'b0);
        wait_idle(n);
`else
        issue(3'd6, 32'd1, 32'd1, 1'b0);
        check("madd_off_busy", 64'(busy), 64'd0);
        issue(3'd7, 32'd2, 32'd3, 1'b0);
        check("msub_off_busy", 64'(busy), 64'd0);
        repeat (6) @(negedge clk);
        check("madd_off_hilo", {hi, lo}, {32'd0, 32'hFFFFFFFF});
`endif

        push("reset_mid_div", 32'd0, 32'd0);
        issue(3'd2, 32'd12345, 32'd7, 1'b0);
        repeat (11) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_busy", 64'(busy), 64'd0);
        check("async_rst_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        push("mult_after_rst", 32'd0, 32'd42);
        issue(3'd0, 32'd7, 32'd6, 1'b0);
        wait_idle(n);
        check("mult2_busy_len", 64'(n), 64'd5);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
